// File: rtl/sample_buf_pkg.sv
// rtl/sample_buf_pkg.sv - shared types and constants for the capture sample buffer
//
// Purpose : state encoding of the sample buffer reader and the sample RAM
//           geometry shared with the capture-side write counter.
// Contents: SAMPLE_ADDR_W  sample RAM address width
//           SAMPLE_DATA_W  sample width in bits
//           rd_state_e     reader FSM states
package sample_buf_pkg;

   localparam int SAMPLE_ADDR_W = 10;
   localparam int SAMPLE_DATA_W = 8;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      FETCH   = 3'd1,
      WAIT    = 3'd2,
      PRESENT = 3'd3,
      DONE    = 3'd4
   } rd_state_e;

endpackage

// File: rtl/sample_buffer_reader.sv
// rtl/sample_buffer_reader.sv - reads the circular capture buffer back to the host, oldest first
//
// Purpose : on in_start, walks all 2**ADDR_W RAM locations beginning at the
//           capture write pointer and hands each byte to the host through a
//           valid/ack handshake.
// Ports   : in_clk, in_reset_n      clock, synchronous active-low reset
//           in_start, in_abort      one-cycle control pulses
//           in_wr_ptr               capture write pointer (oldest sample)
//           out_rd_en, out_rd_addr  RAM read port, data returns next cycle
//           in_rd_data              RAM read data
//           out_data, out_valid     byte to host, held until in_ack
//           in_ack                  host accepts out_data
//           out_busy, out_done      readout in progress / complete
//           out_checksum            running byte sum (SAMPLE_BUFFER_READER_CHECKSUM_EN only)
// Build   : define SAMPLE_BUFFER_READER_CHECKSUM_EN to add the checksum output.
module sample_buffer_reader
   import sample_buf_pkg::*;
#(
   parameter int ADDR_W = SAMPLE_ADDR_W,
   parameter int DATA_W = SAMPLE_DATA_W
) (
   input  logic              in_clk,
   input  logic              in_reset_n,
   input  logic              in_start,
   input  logic              in_abort,
   input  logic [ADDR_W-1:0] in_wr_ptr,
   output logic              out_rd_en,
   output logic [ADDR_W-1:0] out_rd_addr,
   input  logic [DATA_W-1:0] in_rd_data,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              in_ack,
   output logic              out_busy,
`ifdef SAMPLE_BUFFER_READER_CHECKSUM_EN
   output logic [DATA_W-1:0] out_checksum,
`endif
   output logic              out_done
);

   // Count value whose acknowledgement completes the buffer.
   localparam logic [ADDR_W:0] LAST_COUNT = (ADDR_W+1)'((2 ** ADDR_W) - 1);

   rd_state_e         state;
   logic [ADDR_W-1:0] addr;
   logic [ADDR_W:0]   count;
   logic              start_ok;
   logic              ack_ok;
   logic [ADDR_W-1:0] addr_inc;

   // A start is only honoured when no readout is running.
   assign start_ok = in_start && ((state == IDLE) || (state == DONE));
   // PRESENT always has out_valid set, so this is the accepted handshake.
   assign ack_ok   = (state == PRESENT) && in_ack;
   assign addr_inc = addr + ADDR_W'(1);

   always_ff @(posedge in_clk) begin
      if (!in_reset_n) begin
         state       <= IDLE;
         addr        <= '0;
         count       <= '0;
         out_rd_en   <= 1'b0;
         out_rd_addr <= '0;
         out_data    <= '0;
         out_valid   <= 1'b0;
         out_busy    <= 1'b0;
         out_done    <= 1'b0;
      end else if (in_abort) begin
         // out_data and out_rd_addr deliberately keep their last values.
         state     <= IDLE;
         out_rd_en <= 1'b0;
         out_valid <= 1'b0;
         out_busy  <= 1'b0;
         out_done  <= 1'b0;
      end else if (start_ok) begin
         state       <= FETCH;
         addr        <= in_wr_ptr;
         count       <= '0;
         out_rd_en   <= 1'b1;
         out_rd_addr <= in_wr_ptr;
         out_busy    <= 1'b1;
         out_done    <= 1'b0;
      end else begin
         // Read enable is a single-cycle strobe issued on entry to FETCH.
         out_rd_en <= 1'b0;
         case (state)
            FETCH: begin
               state <= WAIT;
            end
            WAIT: begin
               // RAM data for the FETCH address is on in_rd_data now.
               out_data  <= in_rd_data;
               out_valid <= 1'b1;
               state     <= PRESENT;
            end
            PRESENT: begin
               if (in_ack) begin
                  out_valid <= 1'b0;
                  addr      <= addr_inc;
                  count     <= count + (ADDR_W+1)'(1);
                  if (count == LAST_COUNT) begin
                     state    <= DONE;
                     out_busy <= 1'b0;
                     out_done <= 1'b1;
                  end else begin
                     state       <= FETCH;
                     out_rd_en   <= 1'b1;
                     out_rd_addr <= addr_inc;
                  end
               end
            end
            IDLE, DONE: begin
               state <= state;
            end
            default: begin
               state    <= IDLE;
               out_busy <= 1'b0;
               out_done <= 1'b0;
            end
         endcase
      end
   end

`ifdef SAMPLE_BUFFER_READER_CHECKSUM_EN
   // Sum of accepted bytes; survives DONE and abort so the host can read it.
   always_ff @(posedge in_clk) begin
      if (!in_reset_n) begin
         out_checksum <= '0;
      end else if (in_abort) begin
         out_checksum <= out_checksum;
      end else if (start_ok) begin
         out_checksum <= '0;
      end else if (ack_ok) begin
         out_checksum <= out_checksum + out_data;
      end
   end
`endif

endmodule
